// File: rtl/uart_pkg.sv
// Shared UART constants and word type; the RX and TX FIFO instances take their defaults from here.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_ADDR_W = 4;

    typedef logic [UART_DATA_W-1:0] uart_word_t;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART FIFO: one synchronous write port and one asynchronous read port, no reset.
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              UART_CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge UART_CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART byte FIFO with occupancy, almost flags, sticky error flags, flush and FWFT/registered read.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int ADDR_W   = UART_ADDR_W,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter bit FWFT     = 1'b1
) (
    input  logic              UART_CLK,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_V    = (ADDR_W+1)'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("uart_sync_fifo: AF_LEVEL must lie in 1..2^ADDR_W");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
        $error("uart_sync_fifo: AE_LEVEL must lie in 0..2^ADDR_W-1");
    end

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] mem_q;
    logic              rd_acc;
    logic              wr_acc;

    // Occupancy comes straight from the pointer difference; the wrap bit disambiguates full from empty.
    assign level        = wr_ptr - rd_ptr;
    assign empty        = (level == '0);
    assign full         = (level == DEPTH_V);
    assign almost_full  = (level >= AF_V);
    assign almost_empty = (level <= AE_V);

    assign rd_acc = rd_en & ~empty & ~clear;
    assign wr_acc = wr_en & (~full | rd_acc) & ~clear;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .UART_CLK (UART_CLK),
        .wr_en    (wr_acc),
        .wr_addr  (wr_ptr[ADDR_W-1:0]),
        .wr_data  (wr_data),
        .rd_addr  (rd_ptr[ADDR_W-1:0]),
        .rd_data  (mem_q)
    );

    // A flush wins over any request in the same cycle and never raises an error flag.
    always_ff @(posedge UART_CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign rd_data = empty ? '0 : mem_q;
    end else begin : g_registered
        logic [DATA_W-1:0] rd_q;

        always_ff @(posedge UART_CLK or negedge reset) begin
            if (!reset) begin
                rd_q <= '0;
            end else if (clear) begin
                rd_q <= '0;
            end else if (rd_acc) begin
                rd_q <= mem_q;
            end
        end

        assign rd_data = rd_q;
    end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Self-checking bench: FWFT and registered-read FIFOs driven in lockstep against a queue-based model.
module tb_uart_sync_fifo;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              UART_CLK = 1'b0;
    logic              reset;
    logic              clear;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;

    logic [DATA_W-1:0] rd_data_ft, rd_data_rg;
    logic              full_ft, full_rg, empty_ft, empty_rg;
    logic              af_ft, af_rg, ae_ft, ae_rg;
    logic [ADDR_W:0]   level_ft, level_rg;
    logic              ovf_ft, ovf_rg, unf_ft, unf_rg;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] model_q[$];
    logic              model_ovf;
    logic              model_unf;
    logic [DATA_W-1:0] model_reg;

    always #5 UART_CLK = ~UART_CLK;

    uart_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b1)) dut_ft (
        .UART_CLK (UART_CLK), .reset (reset), .clear (clear),
        .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en), .rd_data (rd_data_ft),
        .full (full_ft), .empty (empty_ft), .almost_full (af_ft), .almost_empty (ae_ft),
        .level (level_ft), .overflow (ovf_ft), .underflow (unf_ft)
    );

    uart_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b0)) dut_rg (
        .UART_CLK (UART_CLK), .reset (reset), .clear (clear),
        .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en), .rd_data (rd_data_rg),
        .full (full_rg), .empty (empty_rg), .almost_full (af_rg), .almost_empty (ae_rg),
        .level (level_rg), .overflow (ovf_rg), .underflow (unf_rg)
    );

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        model_reg = '0;
    endtask

    // The model works purely on queue occupancy: reject, pop, then push.
    task automatic modelStep(input logic clr, input logic we, input logic [DATA_W-1:0] wd, input logic re);
        bit rd_ok;
        bit wr_ok;
        if (clr) begin
            modelReset();
        end else begin
            rd_ok = re && (model_q.size() > 0);
            wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
            if (re && model_q.size() == 0) model_unf = 1'b1;
            if (we && !wr_ok) model_ovf = 1'b1;
            if (rd_ok) model_reg = model_q.pop_front();
            if (wr_ok) model_q.push_back(wd);
        end
    endtask

    task automatic checkOutput(input string ctx);
        int n;
        logic [DATA_W-1:0] head;
        n = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        checkValue({ctx, ".level_ft"}, 32'(level_ft), 32'(n));
        checkValue({ctx, ".level_rg"}, 32'(level_rg), 32'(n));
        checkValue({ctx, ".full"}, 32'({full_ft, full_rg}), 32'({2{n == DEPTH}}));
        checkValue({ctx, ".empty"}, 32'({empty_ft, empty_rg}), 32'({2{n == 0}}));
        checkValue({ctx, ".almost_full"}, 32'({af_ft, af_rg}), 32'({2{n >= 12}}));
        checkValue({ctx, ".almost_empty"}, 32'({ae_ft, ae_rg}), 32'({2{n <= 4}}));
        checkValue({ctx, ".overflow"}, 32'({ovf_ft, ovf_rg}), 32'({2{model_ovf}}));
        checkValue({ctx, ".underflow"}, 32'({unf_ft, unf_rg}), 32'({2{model_unf}}));
        checkValue({ctx, ".rd_data_ft"}, 32'(rd_data_ft), 32'(head));
        checkValue({ctx, ".rd_data_rg"}, 32'(rd_data_rg), 32'(model_reg));
    endtask

    task automatic applyStimulus(input string ctx, input logic clr, input logic we,
                                 input logic [DATA_W-1:0] wd, input logic re);
        clear   = clr;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge UART_CLK);
        modelStep(clr, we, wd, re);
        #1;
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        checkOutput(ctx);
    endtask

    initial begin
        reset   = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        modelReset();
        #1;
        checkOutput("por");
        repeat (2) @(posedge UART_CLK);
        @(negedge UART_CLK);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus("fill", 1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
        end
        applyStimulus("fill_over", 1'b0, 1'b1, 8'h99, 1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus("drain", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        applyStimulus("drain_under", 1'b0, 1'b0, 8'h00, 1'b1);

        applyStimulus("clr1", 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus("prime8", 1'b0, 1'b1, 8'($urandom), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus("stream", 1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
        end

        applyStimulus("clr2", 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus("refill", 1'b0, 1'b1, 8'($urandom), 1'b0);
        end
        applyStimulus("full_both", 1'b0, 1'b1, 8'h77, 1'b1);
        applyStimulus("full_both2", 1'b0, 1'b1, 8'h78, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("full_pop", 1'b0, 1'b0, 8'h00, 1'b1);
        end

        applyStimulus("clr3", 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus("empty_both", 1'b0, 1'b1, 8'h3C, 1'b1);

        applyStimulus("clr4", 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus("reg_write", 1'b0, 1'b1, 8'hA5, 1'b0);
        applyStimulus("reg_read", 1'b0, 1'b0, 8'h00, 1'b1);

        applyStimulus("clr5", 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus("ovf_fill", 1'b0, 1'b1, 8'($urandom), 1'b0);
        end
        for (int i = 0; i < 11; i++) begin
            applyStimulus("to_level5", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        applyStimulus("clr_with_wr", 1'b1, 1'b1, 8'hEE, 1'b0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus("random", ($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 60),
                          8'($urandom), ($urandom_range(0, 99) < 45));
            if (i == 200) begin
                wr_en = 1'b1;
                rd_en = 1'b1;
                #3;
                reset = 1'b0;
                #1;
                modelReset();
                checkOutput("async_reset");
                wr_en = 1'b0;
                rd_en = 1'b0;
                @(posedge UART_CLK);
                @(negedge UART_CLK);
                reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
